video_port_arbiter: RTL and testbench
=====================================

// Module: video_port_arbiter
// PURPOSE
//  Owns write/read port 1 of the video framebuffer DPRAM (640x480 1bpp, 32 px/word) in the CLK domain.
//  Shares that port between a CPU bus requester and a built-in fill engine (clear/pattern fill of a word range).
//  Arbitration is round-robin. Port 2 (VGA scan-out, CLK_VGA) is untouched by this block.
// PARAMETERS
//  Bufsz   640*480/32  framebuffer size in 32-bit words (9600)
//  Awidth  14          word address width; Bufsz <= 2**Awidth
// PORTS
//  CLK           in   1       system clock
//  RST_          in   1       asynchronous reset, active low
//  CPU_REQ       in   1       CPU access request; held until CPU_ACK
//  CPU_WE        in   1       1 = write, 0 = read
//  CPU_ADDR      in   Awidth  word address
//  CPU_WDATA     in   32      write data
//  CPU_WSEL      in   4       byte enables for write
//  CPU_ACK       out  1       request accepted this cycle (combinational)
//  CPU_RDATA     out  32      read data, valid while CPU_RVALID
//  CPU_RVALID    out  1       one-cycle pulse, 2 cycles after read ACK
//  FILL_START    in   1       start fill (sampled in IDLE only)
//  FILL_ADDR     in   Awidth  first word of fill
//  FILL_COUNT    in   Awidth  number of words to fill; 0 = none
//  FILL_PATTERN  in   32      word written to every filled location
//  FILL_BUSY     out  1       fill in progress
//  FILL_DONE     out  1       one-cycle pulse at fill completion
//  RAM_ADDR      out  Awidth  DPRAM ADDR_1 (registered)
//  RAM_IN        out  32      DPRAM IN_1 (registered)
//  RAM_W_SEL     out  4       DPRAM W_SEL_1 (registered); 0 = read/no write
//  RAM_OUT       in   32      DPRAM OUT_1; 1-cycle registered read
// BEHAVIOUR
//  Reset (async, RST_=0) sets:
//   - state IDLE; FILL_BUSY=0, FILL_DONE=0, CPU_RVALID=0
//   - RAM_ADDR=0, RAM_IN=0, RAM_W_SEL=0; last_grant=FILL
//   - any in-flight read or fill is dropped.
//  FSM IDLE -> FILL:
//   - taken on FILL_START=1 with FILL_COUNT!=0; latches addr, count, pattern.
//   - FILL_BUSY=1 from the next cycle.
//  FILL_START with FILL_COUNT=0: stays IDLE; FILL_DONE pulses the next cycle.
//  FILL_START while in FILL: ignored.
//  Arbitration, one grant per cycle:
//   - IDLE: CPU granted whenever CPU_REQ=1.
//   - FILL, CPU_REQ=0: fill granted every cycle.
//   - FILL, CPU_REQ=1: grant alternates; the winner is the requester not in last_grant.
//   - CPU_ACK=0 on cycles the fill wins.
//  Grant in cycle t: RAM_ADDR/RAM_IN/RAM_W_SEL loaded at the end of t; the DPRAM acts at the end of t+1.
//  Cycles with no grant: RAM_W_SEL <= 0 (RAM_ADDR/RAM_IN hold).
//  CPU write: RAM_W_SEL <= CPU_WSEL.
//  CPU read: RAM_W_SEL <= 0; CPU_RVALID=1 in t+2 with CPU_RDATA=RAM_OUT.
//  Back-to-back CPU grants are allowed: fully pipelined, one access per cycle.
//  CPU_ADDR >= Bufsz: access is acknowledged, but a write is issued with W_SEL=0 and a read returns 32'h0 with normal timing.
//  Fill grant:
//   - RAM_W_SEL <= 4'b1111, RAM_IN <= pattern, RAM_ADDR <= fill_addr.
//   - fill_addr increments and wraps Bufsz-1 -> 0; remaining decrements.
//   - FILL_ADDR >= Bufsz is reduced to FILL_ADDR-Bufsz when latched.
//  Last fill grant in cycle t: FILL_BUSY=0 and FILL_DONE=1 in t+1; state returns to IDLE.
//   - A CPU request in t+1 is granted that cycle.
//  CPU_RDATA is undefined outside CPU_RVALID; it shall read 0 in simulation.
// TESTING
//  T1: write 0xDEADBEEF @5 WSEL=1111, then read @5 -> ACK same cycle, RVALID 2 cycles later, RDATA=DEADBEEF.
//  T2: write WSEL=0010 @7 -> RAM_W_SEL=0010 one cycle after ACK; the bench RAM model updates only byte 1.
//  T3: fill ADDR=100 COUNT=4 PATTERN=FFFF0000, CPU idle -> writes 100..103 on 4 consecutive cycles, BUSY for 4 cycles, one DONE pulse.
//  T4: fill COUNT=3 with CPU_REQ held reading @0 -> ACK on alternate cycles, fill completes in 6 cycles, no lost CPU read.
//  T5: fill ADDR=9598 COUNT=4 -> RAM_ADDR 9598,9599,0,1. Also: COUNT=0 -> DONE pulse and BUSY never set; CPU_ADDR=9600 read -> RDATA=0.
//  T6: RST_ low mid-fill (remaining=2) -> BUSY=0, RAM_W_SEL=0 immediately; after release a new fill runs normally.

Source files
------------

// File: rtl/video_port_arbiter.sv
// Video framebuffer port-1 arbiter: shares the DPRAM write/read port between
// a CPU bus requester and a built-in fill engine using round-robin grants.
module video_port_arbiter #(
   parameter int Bufsz  = 640 * 480 / 32,
   parameter int Awidth = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpuReq_i,
   input  logic              cpuWe_i,
   input  logic [Awidth-1:0] cpuAddr_i,
   input  logic [31:0]       cpuWdata_i,
   input  logic [3:0]        cpuWsel_i,
   output logic              cpuAck_o,
   output logic [31:0]       cpuRdata_o,
   output logic              cpuRvalid_o,
   input  logic              fillStart_i,
   input  logic [Awidth-1:0] fillAddr_i,
   input  logic [Awidth-1:0] fillCount_i,
   input  logic [31:0]       fillPattern_i,
   output logic              fillBusy_o,
   output logic              fillDone_o,
   output logic [Awidth-1:0] ramAddr_o,
   output logic [31:0]       ramIn_o,
   output logic [3:0]        ramWSel_o,
   input  logic [31:0]       ramOut_i
);

   localparam logic [Awidth-1:0] BufszW    = Awidth'(Bufsz);
   localparam logic [Awidth-1:0] BufszLast = Awidth'(Bufsz - 1);

   typedef enum logic {StIdle, StFill} state_e;

   state_e              state_q;
   logic [Awidth-1:0]   fillAddr_q;
   logic [Awidth-1:0]   fillAddr_d;
   logic [Awidth-1:0]   remaining_q;
   logic [31:0]         pattern_q;
   logic                fillBusy_q;
   logic                fillDone_q;
   logic                lastCpu_q;

   logic [Awidth-1:0]   ramAddr_q;
   logic [31:0]         ramIn_q;
   logic [3:0]          ramWSel_q;
   logic                rdPend_q;
   logic                rdOob_q;
   logic                rvalid_q;
   logic                rvalidOob_q;

   logic                cpuGrant;
   logic                fillGrant;
   logic                cpuOob;
   logic [Awidth-1:0]   fillStartAddr;

   // Round-robin grant decision; the CPU always wins while no fill is running
   always_comb begin
      cpuGrant      = 1'b0;
      fillGrant     = 1'b0;
      cpuOob        = (cpuAddr_i >= BufszW);
      fillAddr_d    = (fillAddr_q == BufszLast) ? '0 : fillAddr_q + 1'b1;
      fillStartAddr = (fillAddr_i >= BufszW) ? fillAddr_i - BufszW : fillAddr_i;
      if (state_q == StIdle) begin
         cpuGrant = cpuReq_i;
      end else if (!cpuReq_i) begin
         fillGrant = 1'b1;
      end else begin
         cpuGrant  = !lastCpu_q;
         fillGrant = lastCpu_q;
      end
   end

   // Fill engine FSM: latches the job, walks the word range and flags completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         fillAddr_q  <= '0;
         remaining_q <= '0;
         pattern_q   <= '0;
         fillBusy_q  <= 1'b0;
         fillDone_q  <= 1'b0;
         lastCpu_q   <= 1'b0;
      end else begin
         fillDone_q <= 1'b0;
         if (cpuGrant) begin
            lastCpu_q <= 1'b1;
         end else if (fillGrant) begin
            lastCpu_q <= 1'b0;
         end
         case (state_q)
            StIdle: begin
               if (fillStart_i) begin
                  if (fillCount_i == '0) begin
                     fillDone_q <= 1'b1;
                  end else begin
                     state_q     <= StFill;
                     fillBusy_q  <= 1'b1;
                     fillAddr_q  <= fillStartAddr;
                     remaining_q <= fillCount_i;
                     pattern_q   <= fillPattern_i;
                  end
               end
            end
            StFill: begin
               if (fillGrant) begin
                  fillAddr_q  <= fillAddr_d;
                  remaining_q <= remaining_q - 1'b1;
                  if (remaining_q == Awidth'(1)) begin
                     state_q    <= StIdle;
                     fillBusy_q <= 1'b0;
                     fillDone_q <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Registered DPRAM port drive plus the two-stage CPU read-return pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ramAddr_q   <= '0;
         ramIn_q     <= '0;
         ramWSel_q   <= '0;
         rdPend_q    <= 1'b0;
         rdOob_q     <= 1'b0;
         rvalid_q    <= 1'b0;
         rvalidOob_q <= 1'b0;
      end else begin
         ramWSel_q   <= '0;
         rdPend_q    <= cpuGrant && !cpuWe_i;
         rdOob_q     <= cpuOob;
         rvalid_q    <= rdPend_q;
         rvalidOob_q <= rdOob_q;
         if (cpuGrant) begin
            ramAddr_q <= cpuAddr_i;
            if (cpuWe_i) begin
               ramIn_q   <= cpuWdata_i;
               ramWSel_q <= cpuOob ? 4'b0000 : cpuWsel_i;
            end
         end else if (fillGrant) begin
            ramAddr_q <= fillAddr_q;
            ramIn_q   <= pattern_q;
            ramWSel_q <= 4'b1111;
         end
      end
   end

   assign cpuAck_o    = cpuGrant;
   assign cpuRvalid_o = rvalid_q;
   assign cpuRdata_o  = (rvalid_q && !rvalidOob_q) ? ramOut_i : 32'h0;
   assign fillBusy_o  = fillBusy_q;
   assign fillDone_o  = fillDone_q;
   assign ramAddr_o   = ramAddr_q;
   assign ramIn_o     = ramIn_q;
   assign ramWSel_o   = ramWSel_q;

endmodule

// File: tb/tb_video_port_arbiter.sv
// Directed self-checking bench for video_port_arbiter with a behavioural DPRAM port model.
module tb_video_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        cpuReq;
   logic        cpuWe;
   logic [13:0] cpuAddr;
   logic [31:0] cpuWdata;
   logic [3:0]  cpuWsel;
   logic        cpuAck;
   logic [31:0] cpuRdata;
   logic        cpuRvalid;
   logic        fillStart;
   logic [13:0] fillAddr;
   logic [13:0] fillCount;
   logic [31:0] fillPattern;
   logic        fillBusy;
   logic        fillDone;
   logic [13:0] ramAddr;
   logic [31:0] ramIn;
   logic [3:0]  ramWSel;
   logic [31:0] ramOut;

   logic        seedReq;
   logic [31:0] mem [0:16383] = '{default: 32'h0};

   int nCompared;
   int nMismatched;

   video_port_arbiter #(.Bufsz(9600), .Awidth(14)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cpuReq_i     (cpuReq),
      .cpuWe_i      (cpuWe),
      .cpuAddr_i    (cpuAddr),
      .cpuWdata_i   (cpuWdata),
      .cpuWsel_i    (cpuWsel),
      .cpuAck_o     (cpuAck),
      .cpuRdata_o   (cpuRdata),
      .cpuRvalid_o  (cpuRvalid),
      .fillStart_i  (fillStart),
      .fillAddr_i   (fillAddr),
      .fillCount_i  (fillCount),
      .fillPattern_i(fillPattern),
      .fillBusy_o   (fillBusy),
      .fillDone_o   (fillDone),
      .ramAddr_o    (ramAddr),
      .ramIn_o      (ramIn),
      .ramWSel_o    (ramWSel),
      .ramOut_i     (ramOut)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // DPRAM port-1 model: byte-enabled write and one-cycle registered read
   always @(posedge clk) begin
      if (seedReq) begin
         mem[0]    <= 32'hCAFEF00D;
         mem[9600] <= 32'h12345678;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (ramWSel[b]) mem[ramAddr][b*8 +: 8] <= ramIn[b*8 +: 8];
         end
      end
      ramOut <= mem[ramAddr];
   end

   task automatic clearInputs();
      cpuReq      = 1'b0;
      cpuWe       = 1'b0;
      cpuAddr     = '0;
      cpuWdata    = '0;
      cpuWsel     = '0;
      fillStart   = 1'b0;
      fillAddr    = '0;
      fillCount   = '0;
      fillPattern = '0;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      seedReq = 1'b1;
      clearInputs();
      repeat (3) @(negedge clk);
      nCompared++;
      if (fillBusy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %0b expected 0", fillBusy); end
      nCompared++;
      if (fillDone !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done: got %0b expected 0", fillDone); end
      nCompared++;
      if (cpuRvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rvalid: got %0b expected 0", cpuRvalid); end
      nCompared++;
      if (ramAddr !== 14'd0 || ramIn !== 32'h0 || ramWSel !== 4'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_ram: got addr=%0d in=%h wsel=%b expected 0/0/0", ramAddr, ramIn, ramWSel);
      end
      nCompared++;
      if (cpuRdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rdata: got %h expected 0", cpuRdata); end
      rst_n   = 1'b1;
      seedReq = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 14'd5; cpuWdata = 32'hDEADBEEF; cpuWsel = 4'b1111;
      #1;
      nCompared++;
      if (cpuAck !== 1'b1) begin nMismatched++; $display("[TB] FAIL t1_write_ack: got %0b expected 1", cpuAck); end
      @(negedge clk);
      nCompared++;
      if (ramAddr !== 14'd5 || ramWSel !== 4'b1111 || ramIn !== 32'hDEADBEEF) begin
         nMismatched++;
         $display("[TB] FAIL t1_write_port: got addr=%0d wsel=%b in=%h expected 5/1111/deadbeef", ramAddr, ramWSel, ramIn);
      end
      cpuWe = 1'b0;
      #1;
      nCompared++;
      if (cpuAck !== 1'b1) begin nMismatched++; $display("[TB] FAIL t1_read_ack: got %0b expected 1", cpuAck); end
      @(negedge clk);
      cpuReq = 1'b0;
      nCompared++;
      if (cpuRvalid !== 1'b0 || ramWSel !== 4'b0000) begin
         nMismatched++;
         $display("[TB] FAIL t1_read_issue: got rvalid=%0b wsel=%b expected 0/0000", cpuRvalid, ramWSel);
      end
      @(negedge clk);
      nCompared++;
      if (cpuRvalid !== 1'b1 || cpuRdata !== 32'hDEADBEEF) begin
         nMismatched++;
         $display("[TB] FAIL t1_read_data: got rvalid=%0b rdata=%h expected 1/deadbeef", cpuRvalid, cpuRdata);
      end
      @(negedge clk);
      nCompared++;
      if (cpuRvalid !== 1'b0 || cpuRdata !== 32'h0) begin
         nMismatched++;
         $display("[TB] FAIL t1_rvalid_pulse: got rvalid=%0b rdata=%h expected 0/0", cpuRvalid, cpuRdata);
      end
   endtask

   task automatic test_byte_write();
      cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 14'd7; cpuWdata = 32'h11223344; cpuWsel = 4'b1111;
      @(negedge clk);
      cpuWdata = 32'hAABBCCDD; cpuWsel = 4'b0010;
      @(negedge clk);
      cpuWe = 1'b0;
      nCompared++;
      if (ramWSel !== 4'b0010 || ramAddr !== 14'd7) begin
         nMismatched++;
         $display("[TB] FAIL t2_wsel: got wsel=%b addr=%0d expected 0010/7", ramWSel, ramAddr);
      end
      @(negedge clk);
      cpuReq = 1'b0;
      @(negedge clk);
      nCompared++;
      if (cpuRvalid !== 1'b1 || cpuRdata !== 32'h1122CC44) begin
         nMismatched++;
         $display("[TB] FAIL t2_byte_merge: got rvalid=%0b rdata=%h expected 1/1122cc44", cpuRvalid, cpuRdata);
      end
      @(negedge clk);
   endtask

   task automatic test_fill();
      fillStart = 1'b1; fillAddr = 14'd100; fillCount = 14'd4; fillPattern = 32'hFFFF0000;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         fillStart = 1'b0;
         nCompared++;
         if (fillBusy !== (k <= 4) || fillDone !== (k == 5)) begin
            nMismatched++;
            $display("[TB] FAIL t3_flags_c%0d: got busy=%0b done=%0b expected %0b/%0b", k, fillBusy, fillDone, k <= 4, k == 5);
         end
         if (k >= 2 && k <= 5) begin
            nCompared++;
            if (ramAddr !== 14'(100 + k - 2) || ramWSel !== 4'b1111 || ramIn !== 32'hFFFF0000) begin
               nMismatched++;
               $display("[TB] FAIL t3_port_c%0d: got addr=%0d wsel=%b in=%h expected %0d/1111/ffff0000", k, ramAddr, ramWSel, ramIn, 100 + k - 2);
            end
         end
      end
      nCompared++;
      if (ramWSel !== 4'b0000) begin nMismatched++; $display("[TB] FAIL t3_idle_wsel: got %b expected 0000", ramWSel); end
      nCompared++;
      if (mem[100] !== 32'hFFFF0000 || mem[103] !== 32'hFFFF0000 || mem[99] !== 32'h0 || mem[104] !== 32'h0) begin
         nMismatched++;
         $display("[TB] FAIL t3_mem: got m99=%h m100=%h m103=%h m104=%h expected 0/ffff0000/ffff0000/0", mem[99], mem[100], mem[103], mem[104]);
      end
   endtask

   task automatic test_fill_contention();
      int rvalidSeen;
      rvalidSeen = 0;
      fillStart = 1'b1; fillAddr = 14'd200; fillCount = 14'd3; fillPattern = 32'h5A5A5A5A;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (cpuRvalid === 1'b1) begin
            rvalidSeen++;
            nCompared++;
            if (cpuRdata !== 32'hCAFEF00D) begin
               nMismatched++;
               $display("[TB] FAIL t4_rdata_c%0d: got %h expected cafef00d", k, cpuRdata);
            end
         end
         nCompared++;
         if (cpuRvalid !== (k == 3 || k == 5 || k == 7 || k == 9)) begin
            nMismatched++;
            $display("[TB] FAIL t4_rvalid_c%0d: got %0b expected %0b", k, cpuRvalid, k == 3 || k == 5 || k == 7 || k == 9);
         end
         nCompared++;
         if (fillBusy !== (k <= 6) || fillDone !== (k == 7)) begin
            nMismatched++;
            $display("[TB] FAIL t4_flags_c%0d: got busy=%0b done=%0b expected %0b/%0b", k, fillBusy, fillDone, k <= 6, k == 7);
         end
         fillStart = 1'b0;
         cpuReq = (k <= 7); cpuWe = 1'b0; cpuAddr = 14'd0;
         #1;
         nCompared++;
         if (cpuAck !== (k <= 7 && (k % 2) == 1)) begin
            nMismatched++;
            $display("[TB] FAIL t4_ack_c%0d: got %0b expected %0b", k, cpuAck, k <= 7 && (k % 2) == 1);
         end
      end
      nCompared++;
      if (rvalidSeen != 4) begin nMismatched++; $display("[TB] FAIL t4_read_count: got %0d expected 4", rvalidSeen); end
      nCompared++;
      if (mem[200] !== 32'h5A5A5A5A || mem[202] !== 32'h5A5A5A5A || mem[203] !== 32'h0) begin
         nMismatched++;
         $display("[TB] FAIL t4_mem: got m200=%h m202=%h m203=%h expected 5a5a5a5a/5a5a5a5a/0", mem[200], mem[202], mem[203]);
      end
   endtask

   task automatic test_wrap_and_edges();
      logic [13:0] expAddr [4];
      expAddr[0] = 14'd9598; expAddr[1] = 14'd9599; expAddr[2] = 14'd0; expAddr[3] = 14'd1;
      fillStart = 1'b1; fillAddr = 14'd9598; fillCount = 14'd4; fillPattern = 32'h0000FFFF;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         fillStart = 1'b0;
         if (k >= 2 && k <= 5) begin
            nCompared++;
            if (ramAddr !== expAddr[k-2] || ramWSel !== 4'b1111) begin
               nMismatched++;
               $display("[TB] FAIL t5_wrap_c%0d: got addr=%0d wsel=%b expected %0d/1111", k, ramAddr, ramWSel, expAddr[k-2]);
            end
         end
      end
      fillStart = 1'b1; fillCount = 14'd0; fillAddr = 14'd50;
      @(negedge clk);
      fillStart = 1'b0;
      nCompared++;
      if (fillDone !== 1'b1 || fillBusy !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL t5_zero_done: got done=%0b busy=%0b expected 1/0", fillDone, fillBusy);
      end
      @(negedge clk);
      nCompared++;
      if (fillDone !== 1'b0 || fillBusy !== 1'b0 || ramWSel !== 4'b0000) begin
         nMismatched++;
         $display("[TB] FAIL t5_zero_after: got done=%0b busy=%0b wsel=%b expected 0/0/0000", fillDone, fillBusy, ramWSel);
      end
      fillStart = 1'b1; fillAddr = 14'd9601; fillCount = 14'd1; fillPattern = 32'h77777777;
      @(negedge clk);
      fillStart = 1'b0;
      @(negedge clk);
      nCompared++;
      if (ramAddr !== 14'd1 || ramWSel !== 4'b1111 || ramIn !== 32'h77777777) begin
         nMismatched++;
         $display("[TB] FAIL t5_fill_addr_reduce: got addr=%0d wsel=%b in=%h expected 1/1111/77777777", ramAddr, ramWSel, ramIn);
      end
      @(negedge clk);
      cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 14'd9600; cpuWdata = 32'hBAD0BAD0; cpuWsel = 4'b1111;
      #1;
      nCompared++;
      if (cpuAck !== 1'b1) begin nMismatched++; $display("[TB] FAIL t5_oob_write_ack: got %0b expected 1", cpuAck); end
      @(negedge clk);
      cpuWe = 1'b0;
      nCompared++;
      if (ramWSel !== 4'b0000) begin nMismatched++; $display("[TB] FAIL t5_oob_write_wsel: got %b expected 0000", ramWSel); end
      #1;
      nCompared++;
      if (cpuAck !== 1'b1) begin nMismatched++; $display("[TB] FAIL t5_oob_read_ack: got %0b expected 1", cpuAck); end
      @(negedge clk);
      cpuReq = 1'b0;
      @(negedge clk);
      nCompared++;
      if (cpuRvalid !== 1'b1 || cpuRdata !== 32'h0) begin
         nMismatched++;
         $display("[TB] FAIL t5_oob_read_data: got rvalid=%0b rdata=%h expected 1/0", cpuRvalid, cpuRdata);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_fill();
      fillStart = 1'b1; fillAddr = 14'd300; fillCount = 14'd4; fillPattern = 32'h0F0F0F0F;
      @(negedge clk);
      fillStart = 1'b0;
      @(negedge clk);
      @(negedge clk);
      nCompared++;
      if (ramWSel !== 4'b1111 || ramAddr !== 14'd301 || fillBusy !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL t6_pre_reset: got wsel=%b addr=%0d busy=%0b expected 1111/301/1", ramWSel, ramAddr, fillBusy);
      end
      rst_n = 1'b0;
      #1;
      nCompared++;
      if (fillBusy !== 1'b0 || ramWSel !== 4'b0000 || ramAddr !== 14'd0) begin
         nMismatched++;
         $display("[TB] FAIL t6_async_reset: got busy=%0b wsel=%b addr=%0d expected 0/0000/0", fillBusy, ramWSel, ramAddr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      nCompared++;
      if (fillBusy !== 1'b0 || fillDone !== 1'b0 || ramWSel !== 4'b0000) begin
         nMismatched++;
         $display("[TB] FAIL t6_after_release: got busy=%0b done=%0b wsel=%b expected 0/0/0000", fillBusy, fillDone, ramWSel);
      end
      nCompared++;
      if (mem[300] !== 32'h0F0F0F0F || mem[301] !== 32'h0 || mem[302] !== 32'h0) begin
         nMismatched++;
         $display("[TB] FAIL t6_dropped_fill: got m300=%h m301=%h m302=%h expected 0f0f0f0f/0/0", mem[300], mem[301], mem[302]);
      end
      fillStart = 1'b1; fillAddr = 14'd400; fillCount = 14'd2; fillPattern = 32'h3C3C3C3C;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         fillStart = 1'b0;
         nCompared++;
         if (fillBusy !== (k <= 2) || fillDone !== (k == 3)) begin
            nMismatched++;
            $display("[TB] FAIL t6_refill_flags_c%0d: got busy=%0b done=%0b expected %0b/%0b", k, fillBusy, fillDone, k <= 2, k == 3);
         end
         if (k == 2 || k == 3) begin
            nCompared++;
            if (ramAddr !== 14'(400 + k - 2) || ramWSel !== 4'b1111 || ramIn !== 32'h3C3C3C3C) begin
               nMismatched++;
               $display("[TB] FAIL t6_refill_port_c%0d: got addr=%0d wsel=%b in=%h expected %0d/1111/3c3c3c3c", k, ramAddr, ramWSel, ramIn, 400 + k - 2);
            end
         end
      end
   endtask

   // Run every scenario in order and report the totals
   initial begin
      nCompared   = 0;
      nMismatched = 0;
      test_reset();
      test_write_read();
      test_byte_write();
      test_fill();
      test_fill_contention();
      test_wrap_and_edges();
      test_reset_mid_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   // Watchdog so the run always ends even if the sequence above stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
